vga_frame_capture: RTL
======================

# vga_frame_capture

Receive-side counterpart of the VGA scan-out path. Samples an incoming 640x480 VGA pixel stream (RGB888 plus active-low HS/VS/BLANK_N) in the CLOCK_50 domain and locks to frame timing. Reverse-maps each active pixel to a 4-bit index of the fixed 16-colour system palette and writes it to the 307200 x 4 pixel memory at row-major address line*640 + column. Used for loopback self-test of the display path and for capturing frames into the same memory the display reads.

## Interface

- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 19, pixel memory address width
- CLOCK_50  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- PIX_EN  in  1  pixel strobe; stream inputs valid on CLOCK_50 edges where PIX_EN=1 (every other cycle for 25 MHz VGA)
- VGA_R / VGA_G / VGA_B  in  8 each  pixel colour
- VGA_HS, VGA_VS  in  1  sync, active low
- VGA_BLANK_N  in  1  high during active video
- MEM_ADDR  out  ADDR_W  write address
- MEM_DATA  out  4  palette index
- MEM_WREN  out  1  write strobe, one CLOCK_50 cycle per pixel
- LOCKED  out  1  last frame had exact H_ACTIVE x V_ACTIVE geometry
- FRAME_DONE  out  1  one-cycle pulse at end of each good frame
- ERR  out  1  sticky geometry error; cleared only by RESET
- MISS  out  1  sticky: a pixel matched no palette entry; cleared only by RESET

## Operation

- Palette, index 0..15: 090300, DB2D20, 01A252, FDED02, 01A0E4, A16A94, B5E4F4, A5A2A2, 5C5855, E8BBD0, 3A3432, 4A4543, 807D7C, D6D5D4, CDAB53, F7F7F7.
- Encode: exact 24-bit match gives that index. No match gives 0 and sets MISS.
- Stage 1: on a PIX_EN edge, register RGB, HS, VS and BLANK_N. VS-assert is detected as VS 1->0 between consecutive PIX_EN samples. End-of-line is detected as BLANK_N 1->0.
- Counters:
  - col: 0..H_ACTIVE-1. Increments per active sample; cleared at end-of-line.
  - line: increments at end-of-line; cleared at VS-assert.
  - addr: increments per written pixel; cleared at VS-assert.
- FSM states:
  - SEARCH: reset state. On VS-assert, go to CAPTURE.
  - CAPTURE: every active sample with col<H_ACTIVE and line<V_ACTIVE is written.
    - A line with col reaching H_ACTIVE while still active, or ending with col≠H_ACTIVE, sets a frame-bad flag. Excess pixels are not written.
    - Active video with line≥V_ACTIVE also sets frame-bad.
    - On the next VS-assert: if line==V_ACTIVE and not frame-bad, set LOCKED=1 and pulse FRAME_DONE. Otherwise set LOCKED=0 and ERR=1.
    - Either way, clear counters and frame-bad and stay in CAPTURE.
- HS is sampled but unused for geometry; BLANK_N is authoritative.
- Arithmetic: addr is ADDR_W bits. It never exceeds H_ACTIVE*V_ACTIVE-1 because writes are gated, so it never wraps.
- A simultaneous end-of-line and VS-assert counts the line, then performs the frame check.

## Timing

- Reset values: MEM_ADDR=0, MEM_DATA=0, MEM_WREN=0, LOCKED=0, FRAME_DONE=0, ERR=0, MISS=0. FSM=SEARCH, all counters 0.
- Asynchronous RESET mid-frame: everything returns to reset values immediately. The partial frame is discarded and capture resumes at the next VS-assert.
- Latency: a pixel sampled at edge N (PIX_EN=1) drives MEM_ADDR/MEM_DATA/MEM_WREN=1 from edge N+1 for exactly one cycle.
- Address and data are stable while MEM_WREN=1.
- FRAME_DONE and the LOCKED/ERR update occur one cycle after the VS-assert sample edge.
- No backpressure: the memory must accept one write per PIX_EN period.
- PIX_EN=0 cycles change no state except deasserting MEM_WREN and FRAME_DONE.

## Test plan

- Reset, then two full 800x525 frames with pixel (x,y) coloured palette[(x+y)%16], PIX_EN every other cycle.
  - Required: 307200 writes per frame; address (y*640+x) carries data (x+y)%16.
  - Required: FRAME_DONE pulses at the start of the second and third VS-asserts; LOCKED=1; ERR=0; MISS=0.
- Pixel (10,5) set to 123456.
  - Required: address 3210 written with 0; MISS=1 and stays 1; LOCKED remains 1.
- Line 100 given 641 active pixels.
  - Required: 641st pixel not written.
  - Required: at next VS-assert, LOCKED=0, ERR=1, no FRAME_DONE.
  - Required: a following good frame restores LOCKED=1 with FRAME_DONE, while ERR stays 1.
- Frame with only 479 active lines.
  - Required: at VS-assert, LOCKED=0, ERR=1.
- RESET pulsed mid-line of line 200 while locked.
  - Required: all outputs 0 immediately; no writes until the next VS-assert; the next full frame gives FRAME_DONE and LOCKED=1.
- Stream started mid-frame, line 300.
  - Required: no writes before the first VS-assert.
  - Required: the first full frame after it writes addresses 0..307199 and gives FRAME_DONE.

Source files
------------

// File: rtl/vga_frame_capture_if.sv
// rtl/vga_frame_capture_if.sv - VGA input stream and pixel-memory write port bundle
interface vga_frame_capture_if #(
  parameter int ADDR_W = 19
);
  logic              pix_en;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              hs;
  logic              vs;
  logic              blank_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_data;
  logic              mem_wren;

  modport master (
    output pix_en, r, g, b, hs, vs, blank_n,
    input  mem_addr, mem_data, mem_wren
  );

  modport slave (
    input  pix_en, r, g, b, hs, vs, blank_n,
    output mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA receive path: frame lock, palette reverse-map, pixel memory write
// Geometry is judged from BLANK_N edges only; HS is carried on the bus but not needed here.
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic               clk_i,
  input  logic               rst_i,
  vga_frame_capture_if.slave bus,
  output logic               locked_o,
  output logic               frame_done_o,
  output logic               err_o,
  output logic               miss_o
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  H_LIM = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_LIM = LINE_W'(V_ACTIVE);

  localparam logic [23:0] PALETTE [16] = '{
    24'h090300, 24'hDB2D20, 24'h01A252, 24'hFDED02,
    24'h01A0E4, 24'hA16A94, 24'hB5E4F4, 24'hA5A2A2,
    24'h5C5855, 24'hE8BBD0, 24'h3A3432, 24'h4A4543,
    24'h807D7C, 24'hD6D5D4, 24'hCDAB53, 24'hF7F7F7
  };

  typedef enum logic {
    SEARCH  = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               bad_q, bad_d;
  logic               vs_q, vs_d;
  logic               blank_q, blank_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [3:0]         mem_data_q, mem_data_d;
  logic               wren_q, wren_d;
  logic               frame_done_q, frame_done_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               miss_q, miss_d;

  logic               vs_fall;
  logic               eol;
  logic               hit;
  logic [3:0]         idx;

  always_comb begin : encode
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && ({bus.r, bus.g, bus.b} == PALETTE[i])) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    addr_d       = addr_q;
    bad_d        = bad_q;
    vs_d         = vs_q;
    blank_d      = blank_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    wren_d       = 1'b0;
    frame_done_d = 1'b0;
    locked_d     = locked_q;
    err_d        = err_q;
    miss_d       = miss_q;
    vs_fall      = 1'b0;
    eol          = 1'b0;

    if (bus.pix_en) begin
      vs_d    = bus.vs;
      blank_d = bus.blank_n;
      vs_fall = vs_q & ~bus.vs;
      eol     = blank_q & ~bus.blank_n;

      case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_d = CAPTURE;
            col_d   = '0;
            line_d  = '0;
            addr_d  = '0;
            bad_d   = 1'b0;
          end
        end

        CAPTURE: begin
          // The closing line is counted before a coincident VS judges the frame.
          if (eol) begin
            if (col_d != H_LIM) begin
              bad_d = 1'b1;
            end
            col_d = '0;
            if (line_d < V_LIM) begin
              line_d = line_d + 1'b1;
            end
          end

          if (vs_fall) begin
            if ((line_d == V_LIM) && !bad_d) begin
              locked_d     = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              locked_d = 1'b0;
              err_d    = 1'b1;
            end
            col_d  = '0;
            line_d = '0;
            addr_d = '0;
            bad_d  = 1'b0;
          end

          // Out-of-window pixels only mark the frame; counters saturate so nothing wraps.
          if (bus.blank_n) begin
            if ((line_d >= V_LIM) || (col_d >= H_LIM)) begin
              bad_d = 1'b1;
            end else begin
              mem_addr_d = addr_d;
              mem_data_d = hit ? idx : 4'd0;
              wren_d     = 1'b1;
              miss_d     = miss_q | ~hit;
              addr_d     = addr_d + 1'b1;
              col_d      = col_d + 1'b1;
            end
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= SEARCH;
      col_q        <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      bad_q        <= 1'b0;
      vs_q         <= 1'b0;
      blank_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      wren_q       <= 1'b0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      bad_q        <= bad_d;
      vs_q         <= vs_d;
      blank_q      <= blank_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      wren_q       <= wren_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      miss_q       <= miss_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.mem_wren  = wren_q;
  assign locked_o      = locked_q;
  assign frame_done_o  = frame_done_q;
  assign err_o         = err_q;
  assign miss_o        = miss_q;

endmodule
